if_id_stage: RTL and testbench

IF/ID pipeline stage sitting directly downstream of the fetch unit. It captures the fetched pc/instr pair, detects load-use hazards against the instruction in EX, and drives keep back to fetch. It also flushes on jump, inserts bubbles while fetch is in its startup lookup (extend), and counts stall cycles for performance monitoring.

---
 rtl/if_id_stage.sv | 139 +++++++++++++
 tb/tb_if_id_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// -----------------------------------------------------------------------------
// if_id_stage
//
// IF/ID pipeline register placed directly after the fetch unit. It captures the
// fetched pc/instr pair and detects load-use hazards against the load in EX.
// It also flushes on a resolved jump and inserts bubbles while fetch is doing
// its startup lookup. A saturating counter records the number of stalled
// cycles.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   fetch_pc      pc from fetch unit
//   fetch_instr   instruction from fetch unit
//   fetch_extend  fetch still in lookup; fetch_pc/fetch_instr not valid
//   jump          control transfer resolved downstream; flush IF/ID
//   ex_mem_read   instruction in EX is a load
//   ex_rt         destination register of the load in EX
//   ext_stall     stall request from later stages
//   keep          to fetch: hold pc this cycle
//   ex_bubble     to ID/EX: insert NOP instead of the decoded instruction
//   id_pc         registered pc of the instruction in ID
//   id_instr      registered instruction in ID
//   id_valid      id_instr is a real instruction
//   stall_cnt     saturating count of stalled cycles
// -----------------------------------------------------------------------------
module if_id_stage #(
  parameter int CNTWIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         fetch_pc,
  input  logic [31:0]         fetch_instr,
  input  logic                fetch_extend,
  input  logic                jump,
  input  logic                ex_mem_read,
  input  logic [4:0]          ex_rt,
  input  logic                ext_stall,
  output logic                keep,
  output logic                ex_bubble,
  output logic [31:0]         id_pc,
  output logic [31:0]         id_instr,
  output logic                id_valid,
  output logic [CNTWIDTH-1:0] stall_cnt
);

  // Opcodes whose rt field is a source operand.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [31:0]         id_pc_q,     id_pc_d;
  logic [31:0]         id_instr_q,  id_instr_d;
  logic                id_valid_q,  id_valid_d;
  logic [CNTWIDTH-1:0] stall_cnt_q, stall_cnt_d;

  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       uses_rt;
  logic       hazard;
  logic       stall;

  assign opcode = id_instr_q[31:26];
  assign rs     = id_instr_q[25:21];
  assign rt     = id_instr_q[20:16];

  // rs is treated as always read. Assuming an operand is used when it is not
  // only costs a spurious stall. rt is a source only for R-type, branches
  // and stores. For loads and immediates, rt is a destination.
  assign uses_rt = (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
                   (opcode == OP_BNE)   || (opcode == OP_SW);

  // $0 never carries a real dependency, so a load into it is ignored.
  assign hazard = id_valid_q && ex_mem_read && (ex_rt != 5'd0) &&
                  ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));

  assign stall = hazard | ext_stall;

  // A jump redirects fetch, so fetch must not hold its pc. While reset is
  // asserted, fetch is not told to hold either, even if a later stage is
  // still requesting a stall.
  assign keep      = stall & ~jump & rst;
  assign ex_bubble = hazard | ~id_valid_q;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    id_pc_d     = id_pc_q;
    id_instr_d  = id_instr_q;
    id_valid_d  = id_valid_q;
    stall_cnt_d = stall_cnt_q;

    if (jump) begin
      // A flush outranks both a stall and an extend. The pc is left as is
      // because it is meaningless once id_valid is low.
      id_valid_d = 1'b0;
      id_instr_d = 32'h0000_0000;
    end else if (stall) begin
      // Hold the current contents.
    end else if (fetch_extend) begin
      id_valid_d = 1'b0;
      id_instr_d = 32'h0000_0000;
    end else begin
      id_pc_d    = fetch_pc;
      id_instr_d = fetch_instr;
      id_valid_d = 1'b1;
    end

    // Only cycles that stall a real instruction are counted. The counter
    // stops at all-ones instead of wrapping.
    if (stall && id_valid_q && !jump && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNTWIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_pc_q     <= 32'h0000_0000;
      id_instr_q  <= 32'h0000_0000;
      id_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      id_pc_q     <= id_pc_d;
      id_instr_q  <= id_instr_d;
      id_valid_q  <= id_valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign id_pc     = id_pc_q;
  assign id_instr  = id_instr_q;
  assign id_valid  = id_valid_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// -----------------------------------------------------------------------------
// tb_if_id_stage
//
// Directed testbench for if_id_stage. It runs two instances that share every
// input: the default 16-bit counter and a 2-bit counter used to observe
// saturation.
// -----------------------------------------------------------------------------
module tb_if_id_stage;

  logic        clk;
  logic        rst;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic        fetch_extend;
  logic        jump;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        ext_stall;

  logic        keep,  keep2;
  logic        ex_bubble, ex_bubble2;
  logic [31:0] id_pc, id_pc2;
  logic [31:0] id_instr, id_instr2;
  logic        id_valid, id_valid2;
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] I_LW8  = 32'h8C08_0000; // lw  $8,0($0)
  localparam logic [31:0] I_ADD  = 32'h0109_5020; // add $10,$8,$9
  localparam logic [31:0] I_LW9  = 32'h8D49_0000; // lw  $9,0($10)
  localparam logic [31:0] I_SW   = 32'hAD49_0004; // sw  $9,4($10)
  localparam logic [31:0] I_NEXT = 32'h0000_0020;

  if_id_stage #(.CNTWIDTH(16)) dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
    .fetch_extend(fetch_extend), .jump(jump), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .ext_stall(ext_stall), .keep(keep), .ex_bubble(ex_bubble),
    .id_pc(id_pc), .id_instr(id_instr), .id_valid(id_valid),
    .stall_cnt(stall_cnt)
  );

  if_id_stage #(.CNTWIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
    .fetch_extend(fetch_extend), .jump(jump), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .ext_stall(ext_stall), .keep(keep2), .ex_bubble(ex_bubble2),
    .id_pc(id_pc2), .id_instr(id_instr2), .id_valid(id_valid2),
    .stall_cnt(stall_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; fetch_pc = 32'h0; fetch_instr = 32'h0; fetch_extend = 1'b1;
    jump = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0; ext_stall = 1'b0;
    #12;
    n_checks++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_id_pc: got %h exp %h", id_pc, 32'h0); end
    n_checks++; if (id_instr !== 32'h0) begin n_fail++; $display("FAIL reset_id_instr: got %h exp %h", id_instr, 32'h0); end
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid: got %b exp 0", id_valid); end
    n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d exp 0", stall_cnt); end
    n_checks++; if (keep !== 1'b0) begin n_fail++; $display("FAIL reset_keep: got %b exp 0", keep); end
    rst = 1'b1;
  endtask

  task automatic test_extend();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL extend_valid[%0d]: got %b exp 0", i, id_valid); end
      n_checks++; if (id_instr !== 32'h0) begin n_fail++; $display("FAIL extend_instr[%0d]: got %h exp 0", i, id_instr); end
      n_checks++; if (keep !== 1'b0) begin n_fail++; $display("FAIL extend_keep[%0d]: got %b exp 0", i, keep); end
      n_checks++; if (ex_bubble !== 1'b1) begin n_fail++; $display("FAIL extend_bubble[%0d]: got %b exp 1", i, ex_bubble); end
    end
    fetch_extend = 1'b0; fetch_pc = 32'h400; fetch_instr = I_LW8;
    tick();
    n_checks++; if (id_pc !== 32'h400) begin n_fail++; $display("FAIL first_pc: got %h exp %h", id_pc, 32'h400); end
    n_checks++; if (id_instr !== I_LW8) begin n_fail++; $display("FAIL first_instr: got %h exp %h", id_instr, I_LW8); end
    n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %b exp 1", id_valid); end
    n_checks++; if (ex_bubble !== 1'b0) begin n_fail++; $display("FAIL first_bubble: got %b exp 0", ex_bubble); end
  endtask

  task automatic test_load_use();
    fetch_pc = 32'h404; fetch_instr = I_ADD;
    tick();
    n_checks++; if (id_instr !== I_ADD) begin n_fail++; $display("FAIL lu_load_add: got %h exp %h", id_instr, I_ADD); end
    ex_mem_read = 1'b1; ex_rt = 5'd8; fetch_pc = 32'h408; fetch_instr = I_LW9;
    #1;
    n_checks++; if (keep !== 1'b1) begin n_fail++; $display("FAIL lu_keep: got %b exp 1", keep); end
    n_checks++; if (ex_bubble !== 1'b1) begin n_fail++; $display("FAIL lu_bubble: got %b exp 1", ex_bubble); end
    tick();
    n_checks++; if (id_instr !== I_ADD) begin n_fail++; $display("FAIL lu_held_instr: got %h exp %h", id_instr, I_ADD); end
    n_checks++; if (id_pc !== 32'h404) begin n_fail++; $display("FAIL lu_held_pc: got %h exp %h", id_pc, 32'h404); end
    n_checks++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_stall_cnt: got %0d exp 1", stall_cnt); end
    ex_mem_read = 1'b0;
    #1;
    n_checks++; if (keep !== 1'b0) begin n_fail++; $display("FAIL lu_clear_keep: got %b exp 0", keep); end
    n_checks++; if (ex_bubble !== 1'b0) begin n_fail++; $display("FAIL lu_clear_bubble: got %b exp 0", ex_bubble); end
    tick();
    n_checks++; if (id_pc !== 32'h408) begin n_fail++; $display("FAIL lu_advance_pc: got %h exp %h", id_pc, 32'h408); end
    n_checks++; if (id_instr !== I_LW9) begin n_fail++; $display("FAIL lu_advance_instr: got %h exp %h", id_instr, I_LW9); end
    n_checks++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_cnt_after: got %0d exp 1", stall_cnt); end
  endtask

  // ID holds lw $9,0($10): rs=10, rt=9 (rt is the destination, not a source).
  task automatic test_no_false_hazard();
    ex_mem_read = 1'b1; ex_rt = 5'd9;
    #1;
    n_checks++; if (keep !== 1'b0) begin n_fail++; $display("FAIL nfh_rt_keep: got %b exp 0", keep); end
    n_checks++; if (ex_bubble !== 1'b0) begin n_fail++; $display("FAIL nfh_rt_bubble: got %b exp 0", ex_bubble); end
    ex_rt = 5'd0;
    #1;
    n_checks++; if (keep !== 1'b0) begin n_fail++; $display("FAIL nfh_r0_keep: got %b exp 0", keep); end
    ex_rt = 5'd10;
    #1;
    n_checks++; if (keep !== 1'b1) begin n_fail++; $display("FAIL nfh_rs_keep: got %b exp 1", keep); end
    ex_mem_read = 1'b0; ex_rt = 5'd0;
  endtask

  task automatic test_jump_over_hazard();
    fetch_pc = 32'h40C; fetch_instr = I_ADD;
    tick();
    ex_mem_read = 1'b1; ex_rt = 5'd9;
    #1;
    n_checks++; if (keep !== 1'b1) begin n_fail++; $display("FAIL jmp_rt_hazard_keep: got %b exp 1", keep); end
    jump = 1'b1;
    #1;
    n_checks++; if (keep !== 1'b0) begin n_fail++; $display("FAIL jmp_keep: got %b exp 0", keep); end
    n_checks++; if (ex_bubble !== 1'b1) begin n_fail++; $display("FAIL jmp_bubble: got %b exp 1", ex_bubble); end
    tick();
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL jmp_valid: got %b exp 0", id_valid); end
    n_checks++; if (id_instr !== 32'h0) begin n_fail++; $display("FAIL jmp_instr: got %h exp 0", id_instr); end
    n_checks++; if (id_pc !== 32'h40C) begin n_fail++; $display("FAIL jmp_pc: got %h exp %h", id_pc, 32'h40C); end
    n_checks++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL jmp_cnt: got %0d exp 1", stall_cnt); end
    jump = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0;
  endtask

  task automatic test_ext_stall();
    fetch_pc = 32'h500; fetch_instr = I_SW;
    tick();
    n_checks++; if (id_pc !== 32'h500) begin n_fail++; $display("FAIL es_load_pc: got %h exp %h", id_pc, 32'h500); end
    ext_stall = 1'b1; fetch_pc = 32'h504; fetch_instr = I_NEXT;
    #1;
    n_checks++; if (keep !== 1'b1) begin n_fail++; $display("FAIL es_keep: got %b exp 1", keep); end
    // The 16-bit counter enters this phase at 1; the 2-bit counter tops out at 3.
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (id_pc !== 32'h500) begin n_fail++; $display("FAIL es_pc[%0d]: got %h exp %h", i, id_pc, 32'h500); end
      n_checks++; if (id_instr !== I_SW || id_valid !== 1'b1) begin n_fail++; $display("FAIL es_instr[%0d]: got %h/%b exp %h/1", i, id_instr, id_valid, I_SW); end
      n_checks++; if (stall_cnt !== 16'(2 + i)) begin n_fail++; $display("FAIL es_cnt[%0d]: got %0d exp %0d", i, stall_cnt, 2 + i); end
      n_checks++; if (stall_cnt2 !== 2'((2 + i) > 3 ? 3 : (2 + i))) begin n_fail++; $display("FAIL es_cnt2[%0d]: got %0d exp %0d", i, stall_cnt2, (2 + i) > 3 ? 3 : (2 + i)); end
    end
    ext_stall = 1'b0;
    tick();
    n_checks++; if (id_pc !== 32'h504) begin n_fail++; $display("FAIL es_release_pc: got %h exp %h", id_pc, 32'h504); end
    n_checks++; if (id_instr !== I_NEXT) begin n_fail++; $display("FAIL es_release_instr: got %h exp %h", id_instr, I_NEXT); end
  endtask

  task automatic test_reset_mid_stall();
    ext_stall = 1'b1;
    tick();
    n_checks++; if (stall_cnt !== 16'd7) begin n_fail++; $display("FAIL rms_pre_cnt: got %0d exp 7", stall_cnt); end
    rst = 1'b0;
    #1;
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rms_valid: got %b exp 0", id_valid); end
    n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rms_cnt: got %0d exp 0", stall_cnt); end
    n_checks++; if (stall_cnt2 !== 2'd0) begin n_fail++; $display("FAIL rms_cnt2: got %0d exp 0", stall_cnt2); end
    n_checks++; if (keep !== 1'b0) begin n_fail++; $display("FAIL rms_keep: got %b exp 0", keep); end
    n_checks++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL rms_pc: got %h exp 0", id_pc); end
    ext_stall = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  task automatic test_saturation();
    fetch_pc = 32'h600; fetch_instr = I_ADD;
    tick();
    n_checks++; if (id_valid2 !== 1'b1 || id_pc2 !== 32'h600) begin n_fail++; $display("FAIL sat_load: got %b/%h exp 1/%h", id_valid2, id_pc2, 32'h600); end
    ext_stall = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_checks++; if (stall_cnt !== 16'(k)) begin n_fail++; $display("FAIL sat_cnt16[%0d]: got %0d exp %0d", k, stall_cnt, k); end
      n_checks++; if (stall_cnt2 !== 2'(k > 3 ? 3 : k)) begin n_fail++; $display("FAIL sat_cnt2[%0d]: got %0d exp %0d", k, stall_cnt2, k > 3 ? 3 : k); end
    end
    ext_stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_extend();
    test_load_use();
    test_no_false_hazard();
    test_jump_over_hazard();
    test_ext_stall();
    test_reset_mid_stall();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
